// File: rtl/uart_rx_if.sv
// Receive-side signal bundle for uart_rx: serial line and baud tick in,
// parallel byte, done strobe and framing flag out.
interface uart_rx_if #(
   parameter int DBIT = 8
);
   logic            rx;
   logic            s_tick;
   logic [DBIT-1:0] dout;
   logic            rx_done_tick;
   logic            frame_err;

   modport master (
      output rx, s_tick,
      input  dout, rx_done_tick, frame_err
   );

   modport slave (
      input  rx, s_tick,
      output dout, rx_done_tick, frame_err
   );
endinterface

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: 16x oversampled, mid-bit sampling, one done strobe
// per frame with the stop-bit value reported as a framing error.
module uart_rx #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic     clk,
   input  logic     reset,
   uart_rx_if.slave bus
);
   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   localparam logic [3:0]    S_MID  = 4'd7;
   localparam logic [3:0]    S_LAST = 4'd15;
   localparam logic [3:0]    S_STOP = 4'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

   logic            rx_sync_p0;
   logic            rx_s;
   logic [1:0]      state;
   logic [3:0]      s;
   logic [NW-1:0]   n;
   logic [DBIT-1:0] b;
   logic [DBIT-1:0] dout_r;
   logic            done_r;
   logic            ferr_r;

   // rx is asynchronous; flops reset high so reset release never looks like a start edge
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_sync_p0 <= 1'b1;
         rx_s       <= 1'b1;
      end else begin
         rx_sync_p0 <= bus.rx;
         rx_s       <= rx_sync_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         s      <= '0;
         n      <= '0;
         b      <= '0;
         dout_r <= '0;
         ferr_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state <= START;
                  s     <= '0;
               end
            end
            START: begin
               if (bus.s_tick) begin
                  if (s == S_MID) begin
                     // a start bit that is gone by mid-bit was a glitch
                     state <= rx_s ? IDLE : DATA;
                     s     <= '0;
                     n     <= '0;
                  end else begin
                     s <= s + 4'd1;
                  end
               end
            end
            DATA: begin
               if (bus.s_tick) begin
                  if (s == S_LAST) begin
                     s <= '0;
                     b <= {rx_s, b[DBIT-1:1]};
                     if (n == N_LAST) state <= STOP;
                     else             n     <= n + 1'b1;
                  end else begin
                     s <= s + 4'd1;
                  end
               end
            end
            default: begin
               if (bus.s_tick) begin
                  if (s == S_STOP) begin
                     // leave mid stop bit so a back-to-back start edge is caught
                     state  <= IDLE;
                     dout_r <= b;
                     ferr_r <= ~rx_s;
                     done_r <= 1'b1;
                  end else begin
                     s <= s + 4'd1;
                  end
               end
            end
         endcase
      end
   end

   assign bus.dout         = dout_r;
   assign bus.rx_done_tick = done_r;
   assign bus.frame_err    = ferr_r;
endmodule
